// File: rtl/kb_fifo.sv
// rtl/kb_fifo.sv - keyboard event FIFO with PS/2 set-2 prefix folding
//
// Sits between the PS/2 receiver and the CPU port controller. It folds the E0
// (extended) and F0 (release) prefix bytes into flag bits on the event that
// follows them. Each complete event is stored and pulses irq once.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   kb_done, kb_data    one-cycle byte strobe and byte from the PS/2 receiver
//   rd                  one-cycle pop strobe from the port controller
//   clr                 one-cycle flush strobe; it overrides everything else in the same cycle
//   q                   scancode of the head entry; 0 when empty
//   status              {overflow, 3'b000, ext, rel, full, nonempty}
//   count               number of stored entries, 0..DEPTH
//   irq                 one-cycle pulse per stored entry
module kb_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          kb_done,
  input  logic [7:0]    kb_data,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    q,
  output logic [7:0]    status,
  output logic [AW:0]   count,
  output logic          irq
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Entry layout: {ext, rel, code}
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_rel_q, pend_rel_d;
  logic          irq_q, irq_d;

  logic          empty, full, is_prefix, evt, pop, push, wr_en;
  logic [9:0]    head;

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == DEPTH_C);
    is_prefix = (kb_data == 8'hE0) || (kb_data == 8'hF0);
    evt       = kb_done && !is_prefix;
    pop       = rd && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the event.
    push      = evt && (!full || pop);
    wr_en     = push && !clr;

    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    pend_ext_d = pend_ext_q;
    pend_rel_d = pend_rel_q;
    irq_d      = 1'b0;

    if (clr) begin
      wp_d       = '0;
      rp_d       = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      pend_ext_d = 1'b0;
      pend_rel_d = 1'b0;
    end else begin
      if (kb_done) begin
        if (kb_data == 8'hE0) begin
          pend_ext_d = 1'b1;
        end else if (kb_data == 8'hF0) begin
          pend_rel_d = 1'b1;
        end else begin
          // Prefixes are consumed by the event, even when the event is dropped.
          pend_ext_d = 1'b0;
          pend_rel_d = 1'b0;
        end
      end
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
      if (evt && !push) ovf_d = 1'b1;
      irq_d = push;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pend_ext_q <= pend_ext_d;
      pend_rel_q <= pend_rel_d;
      irq_q      <= irq_d;
    end
  end

  // Storage does not need a reset: an entry is only visible while count covers it.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wp_q] <= {pend_ext_q, pend_rel_q, kb_data};
  end

  assign head   = mem_q[rp_q];
  assign q      = empty ? 8'h00 : head[7:0];
  assign status = {ovf_q, 3'b000, head[9] & !empty, head[8] & !empty, full, !empty};
  assign count  = cnt_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_kb_fifo.sv
// tb/tb_kb_fifo.sv - self-checking bench for kb_fifo against a queue model
module tb_kb_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          kb_done;
  logic [7:0]    kb_data;
  logic          rd;
  logic          clr;
  logic [7:0]    q;
  logic [7:0]    status;
  logic [AW:0]   count;
  logic          irq;

  kb_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .kb_done (kb_done),
    .kb_data (kb_data),
    .rd      (rd),
    .clr     (clr),
    .q       (q),
    .status  (status),
    .count   (count),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of {ext, rel, code} events plus prefix and overflow flags.
  logic [9:0] mq[$];
  bit         m_ext, m_rel, m_ovf, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eq, es;
    bit ne;
    ne = (mq.size() != 0);
    eq = ne ? mq[0][7:0] : 8'h00;
    es = {m_ovf, 3'b000, ne ? mq[0][9] : 1'b0, ne ? mq[0][8] : 1'b0,
          mq.size() == DEPTH, ne};
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".status"}, 32'(status), 32'(es));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
  endtask

  task automatic model_clear();
    mq.delete();
    m_ext = 0; m_rel = 0; m_ovf = 0; m_irq = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs after the edge.
  task automatic step(input string tag, input bit d, input logic [7:0] data,
                      input bit r, input bit c);
    kb_done = d; kb_data = data; rd = r; clr = c;
    m_irq = 0;
    if (c) begin
      model_clear();
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (d) begin
        if (data == 8'hE0) m_ext = 1;
        else if (data == 8'hF0) m_rel = 1;
        else begin
          if (mq.size() < DEPTH) begin
            mq.push_back({m_ext, m_rel, data});
            m_irq = 1;
          end else begin
            m_ovf = 1;
          end
          m_ext = 0; m_rel = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    kb_done = 0; rd = 0; clr = 0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 0;
    #2;
    model_clear();
    check_outputs(tag);
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  initial begin
    logic [7:0] d;
    kb_done = 0; kb_data = 8'h00; rd = 0; clr = 0; reset_n = 1;
    #1;
    do_reset("reset");
    chk("reset.status_const", 32'(status), 32'h00);

    // Push then pop
    step("push1c", 1, 8'h1C, 0, 0);
    chk("push1c.status_const", 32'(status), 32'h01);
    step("push1c.idle", 0, 8'h00, 0, 0);
    step("pop1c", 0, 8'h00, 1, 0);
    chk("pop1c.count_const", 32'(count), 32'h0);

    // Prefix folding
    step("pre.e0", 1, 8'hE0, 0, 0);
    step("pre.f0", 1, 8'hF0, 0, 0);
    step("pre.74", 1, 8'h74, 0, 0);
    chk("pre.status_0d", 32'(status), 32'h0D);
    step("pre.f0b", 1, 8'hF0, 0, 0);
    step("pre.1c", 1, 8'h1C, 0, 0);
    step("pre.pop", 0, 8'h00, 1, 0);
    chk("pre.second_rel", 32'(status), 32'h05);
    step("pre.clr", 0, 8'h00, 0, 1);

    // Overflow: 17 codes into 16 slots
    for (int i = 1; i <= 17; i++) step("ovf.push", 1, 8'(i), 0, 0);
    chk("ovf.status_83", 32'(status), 32'h83);
    chk("ovf.count_16", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf.order", 32'(q), 32'(i));
      step("ovf.pop", 0, 8'h00, 1, 0);
    end
    chk("ovf.sticky", 32'(status), 32'h80);
    step("ovf.clr", 0, 8'h00, 0, 1);

    // Full with simultaneous pop and push
    for (int i = 0; i < 16; i++) step("full.push", 1, 8'(8'h20 + i), 0, 0);
    step("full.both", 1, 8'h55, 1, 0);
    chk("full.count", 32'(count), 32'd16);
    chk("full.no_ovf", 32'(status[7]), 32'd0);
    for (int i = 0; i < 15; i++) step("full.drain", 0, 8'h00, 1, 0);
    chk("full.last55", 32'(q), 32'h55);
    step("full.drain_last", 0, 8'h00, 1, 0);

    // clr beats a same-cycle event; pop on empty
    for (int i = 0; i < 3; i++) step("clr.push", 1, 8'(8'h40 + i), 0, 0);
    step("clr.with33", 1, 8'h33, 0, 1);
    chk("clr.irq0", 32'(irq), 32'd0);
    step("clr.empty_pop", 0, 8'h00, 1, 0);
    step("clr.idle", 0, 8'h00, 0, 0);

    // Wrap-around: 40 push/pop pairs with occupancy held at 0..3
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(1, 8'hDF));
      step("wrap.push", 1, d, (mq.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
      step("wrap.pop", 0, 8'h00, 1'($urandom_range(0, 1)), 0);
    end

    // Random mix including prefixes, overflow and flushes
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      d = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
      step("rand", 1'($urandom_range(0, 3) != 0), d,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
    end

    // Reset mid-prefix drops the pending ext flag
    step("rst.clr", 0, 8'h00, 0, 1);
    step("rst.e0", 1, 8'hE0, 0, 0);
    do_reset("rst.mid");
    step("rst.6b", 1, 8'h6B, 0, 0);
    chk("rst.q6b", 32'(q), 32'h6B);
    chk("rst.ext0", 32'(status[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kb_fifo.md
Name: kb_fifo

Overview:
- Keyboard receive buffer between the PS/2 receiver (done/data strobe) and the CPU port controller.
- Folds the PS/2 set-2 prefixes E0 (extended) and F0 (release) into per-entry flag bits.
- Stores complete key events in a FIFO and raises an interrupt strobe per stored event.
- The CPU reads the head event and status through the port router and pops with a one-cycle strobe. Scancodes are no longer lost when the CPU is slow.

Parameters:
- DEPTH, 16, number of event entries; must be a power of two, 2..256.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clock  in  1  system clock (clock_25 domain)
- reset_n  in  1  asynchronous active-low reset
- kb_done  in  1  one-cycle strobe from PS/2 receiver: kb_data valid
- kb_data  in  8  received byte
- rd  in  1  one-cycle pop strobe from port controller (CPU write to keyboard port)
- clr  in  1  one-cycle flush strobe
- q  out  8  scancode of head entry; 8'h00 when empty
- status  out  8  {overflow, 3'b000, ext, rel, full, nonempty}; ext and rel belong to the head entry, 0 when empty
- count  out  AW+1  number of stored entries, 0..DEPTH
- irq  out  1  one-cycle pulse per entry stored

Behaviour:
- Reset (reset_n=0, async): pointers=0, count=0, overflow=0, pending ext/rel=0, irq=0. Consequently q=0 and status=0.
- Entry format is 10 bits {ext, rel, code}. Storage is a register array with write pointer wp and read pointer rp, both AW bits, wrapping modulo DEPTH.
- q and the status head bits are combinational reads of entry[rp], gated to 0 when count==0.
- Prefix decode on kb_done:
  - byte 8'hE0: set pend_ext=1; nothing stored.
  - byte 8'hF0: set pend_rel=1; nothing stored.
  - any other byte (E1 included): forms the event {pend_ext, pend_rel, byte}, then clears pend_ext and pend_rel.
- Push: an event with count<DEPTH writes entry[wp], then wp+1 and count+1.
  - irq=1 on the following cycle only.
  - Latency: kb_done at cycle N, so nonempty, q and irq are visible at N+1.
- Push when full (count==DEPTH): the event is dropped and overflow<=1 (sticky). Pending prefixes are still cleared, and irq is not pulsed.
- Pop: rd with count>0 gives rp+1 and count-1. The new head is visible the next cycle.
- rd with count==0 is ignored: no pointer change and no error flag.
- Simultaneous push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and overflow does not set.
  - When empty, the push proceeds and the pop is ignored.
- clr has priority over everything in the same cycle. It sets wp=rp=0, count=0, overflow=0, pend_ext=pend_rel=0 and irq=0. A kb_done in the clr cycle is discarded.
- A prefix byte never changes count and never pulses irq.
- full = (count==DEPTH); nonempty = (count!=0).
- A kb_done on consecutive cycles must be accepted each cycle; there is no back-pressure.
- Reset asserted mid-prefix, after E0 but before the code, discards the pending flag. A following code byte is stored with ext=0.
- State is held in counters and pointers only, plus the 2-bit prefix state (IDLE, EXT, REL, EXT_REL) encoded as pend_ext/pend_rel.

Test Plan:
- Push then pop: send kb_done 8'h1C → next cycle q=1C, status=8'h01, count=1, irq one pulse. Then rd → next cycle q=00, status=00, count=0.
- Prefix folding: send E0, F0, 74 → exactly one entry, q=74, status=8'h0D (ext=1, rel=1, nonempty), one irq pulse. Then send F0, 1C → second entry with rel=1, ext=0.
- Overflow: push 17 plain codes 01..11 with DEPTH=16:
  - count=16, status=8'h83 (overflow, full, nonempty), 16 irq pulses.
  - Popping all 16 returns 01..10 in order.
  - overflow stays 1 until clr.
- Full plus simultaneous rd and kb_done 8'h55: count stays 16, overflow stays 0. After draining, the last q is 55.
- clr together with kb_done 8'h33 while 3 entries are held → count=0, status=00, no irq, 33 not stored. Pop when empty → no change.
- Wrap-around: 40 push/pop pairs with count kept between 0 and 3 → data order preserved across the pointer wrap. Then reset_n pulsed low after E0 and 6B sent → q=6B, ext=0.
